l1_cache_access_ctrl: RTL and testbench

- Sequencer in front of the set-associative L1 lookup/update datapath.
- Accepts one CPU access at a time and pulses the datapath find.
- On a miss, fetches the block from the next memory level and drives the datapath update.
- Owns per-set LRU state and supplies the victim way when all ways are valid.

---
 rtl/l1_cache_pkg.sv | 25 ++
 rtl/l1_cache_access_ctrl_lru.sv | 63 ++++++
 rtl/l1_cache_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_l1_cache_access_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// Shared parameters and FSM state encoding for the L1 access controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package l1_cache_pkg;

    localparam int L1_WAY             = 4;
    localparam int L1_BLOCK_SIZE_BYTE = 16;
    localparam int L1_CACHE_SIZE_BYTE = 32768;
    localparam int L1_WAY_W           = 5;

    localparam int L1_OFF_W = $clog2(L1_BLOCK_SIZE_BYTE);
    localparam int L1_SET   = L1_CACHE_SIZE_BYTE / (L1_BLOCK_SIZE_BYTE * L1_WAY);
    localparam int L1_IDX_W = $clog2(L1_SET);
    localparam int L1_TAG_W = 32 - L1_IDX_W - L1_OFF_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        FILL      = 3'd4,
        RESP      = 3'd5
    } state_t;

endpackage

// File: rtl/l1_cache_access_ctrl_lru.sv
// Per-set LRU age table: age 0 = most recent, age WAY-1 = victim.
// Latency: touch takes effect on the next clock; victim read is combinational.
// Backpressure: none, one touch per cycle always accepted.
// Ports: touch_i/touch_set_i/touch_way_i update one set; vic_set_i -> vic_way_o.
module lru_age_table #(
    parameter int WAY   = 4,
    parameter int SET   = 512,
    parameter int IDX_W = 9,
    parameter int WAY_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             touch_i,
    input  logic [IDX_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic [IDX_W-1:0] vic_set_i,
    output logic [WAY_W-1:0] vic_way_o
);

    localparam int AGE_W = $clog2(WAY);

    logic [AGE_W-1:0] age_q [SET][WAY];
    logic [AGE_W-1:0] touched_age;

    // Current age of the way being touched; ways younger than it get older.
    always_comb begin
        touched_age = '0;
        for (int w = 0; w < WAY; w++) begin
            if (touch_way_i == WAY_W'(w)) begin
                touched_age = age_q[touch_set_i][w];
            end
        end
    end

    // Ages are always a permutation, so exactly one way carries the oldest age.
    always_comb begin
        vic_way_o = '0;
        for (int w = 0; w < WAY; w++) begin
            if (age_q[vic_set_i][w] == AGE_W'(WAY - 1)) begin
                vic_way_o = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SET; s++) begin
                for (int w = 0; w < WAY; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (touch_i) begin
            for (int w = 0; w < WAY; w++) begin
                if (touch_way_i == WAY_W'(w)) begin
                    age_q[touch_set_i][w] <= '0;
                end else if (age_q[touch_set_i][w] < touched_age) begin
                    age_q[touch_set_i][w] <= age_q[touch_set_i][w] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/l1_cache_access_ctrl.sv
// L1 access sequencer: lookup, miss fetch from next level, fill, LRU update.
// Latency: hit = accept + 1 + datapath find cycles + 1; miss adds memory and fill time.
// Backpressure: one access in flight, cpu_req_ready only in IDLE; mem_req held until ready.
// Ports: cpu_req/cpu_resp (CPU side), dp_* (lookup/update datapath), mem_req/mem_rsp (next level).
module l1_cache_access_ctrl
    import l1_cache_pkg::*;
#(
    parameter int WAY             = L1_WAY,
    parameter int BLOCK_SIZE_BYTE = L1_BLOCK_SIZE_BYTE,
    parameter int CACHE_SIZE_BYTE = L1_CACHE_SIZE_BYTE,
    parameter int WAY_W           = L1_WAY_W,
    // Derived widths; leave at their defaults.
    parameter int OFF_W           = $clog2(BLOCK_SIZE_BYTE),
    parameter int SET             = CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY),
    parameter int IDX_W           = $clog2(SET),
    parameter int TAG_W           = 32 - IDX_W - OFF_W,
    parameter int BLK_W           = BLOCK_SIZE_BYTE * 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cpu_req_valid,
    output logic             cpu_req_ready,
    input  logic [31:0]      cpu_req_addr,
    output logic             cpu_resp_valid,
    output logic             cpu_resp_hit,
    output logic [WAY_W-1:0] cpu_resp_way,

    output logic [TAG_W-1:0] dp_tag,
    output logic [IDX_W-1:0] dp_index,
    output logic [OFF_W-1:0] dp_block_offset,
    output logic             dp_find_start,
    input  logic             dp_done,
    input  logic             dp_found,
    input  logic [WAY_W-1:0] dp_hit_way,
    output logic             dp_update_start,
    output logic [BLK_W-1:0] dp_block,
    input  logic             dp_replace,
    output logic             dp_block_replace,
    output logic [WAY_W-1:0] dp_replace_way,
    input  logic             dp_updated,
    input  logic [WAY_W-1:0] dp_fill_way,

    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [BLK_W-1:0] mem_rsp_data
);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [BLK_W-1:0]   block_q, block_d;
    logic               find_q, find_d;
    logic               upd_q, upd_d;
    logic               repl_q, repl_d;
    logic               resp_hit_q, resp_hit_d;
    logic [WAY_W-1:0]   resp_way_q, resp_way_d;

    logic               touch;
    logic [WAY_W-1:0]   touch_way;
    logic [WAY_W-1:0]   vic_way;
    logic [WAY_W-1:0]   written_way;

    // All datapath fields come from the latched address only.
    assign dp_tag          = addr_q[31 -: TAG_W];
    assign dp_index        = addr_q[OFF_W +: IDX_W];
    assign dp_block_offset = addr_q[OFF_W-1:0];
    assign mem_req_addr    = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign dp_block        = block_q;
    assign dp_find_start   = find_q;
    assign dp_update_start = upd_q;
    assign dp_block_replace = repl_q;
    assign dp_replace_way  = repl_q ? vic_way : '0;

    lru_age_table #(
        .WAY   (WAY),
        .SET   (SET),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .touch_i     (touch),
        .touch_set_i (dp_index),
        .touch_way_i (touch_way),
        .vic_set_i   (dp_index),
        .vic_way_o   (vic_way)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            block_q    <= '0;
            find_q     <= 1'b0;
            upd_q      <= 1'b0;
            repl_q     <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_way_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            block_q    <= block_d;
            find_q     <= find_d;
            upd_q      <= upd_d;
            repl_q     <= repl_d;
            resp_hit_q <= resp_hit_d;
            resp_way_q <= resp_way_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        block_d        = block_q;
        find_d         = 1'b0;
        upd_d          = 1'b0;
        repl_d         = repl_q;
        resp_hit_d     = resp_hit_q;
        resp_way_d     = resp_way_q;
        touch          = 1'b0;
        touch_way      = '0;
        // The victim is stable through FILL: the LRU only moves on completion.
        written_way    = (repl_q || dp_replace) ? vic_way : dp_fill_way;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_hit   = 1'b0;
        cpu_resp_way   = '0;
        mem_req_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    addr_d  = cpu_req_addr;
                    find_d  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (dp_done) begin
                    if (dp_found) begin
                        touch      = 1'b1;
                        touch_way  = dp_hit_way;
                        resp_hit_d = 1'b1;
                        resp_way_d = dp_hit_way;
                        state_d    = RESP;
                    end else begin
                        state_d = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    block_d = mem_rsp_data;
                    upd_d   = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (dp_updated) begin
                    touch      = 1'b1;
                    touch_way  = written_way;
                    resp_hit_d = 1'b0;
                    resp_way_d = written_way;
                    repl_d     = 1'b0;
                    state_d    = RESP;
                end else if (dp_replace) begin
                    repl_d = 1'b1;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_hit   = resp_hit_q;
                cpu_resp_way   = resp_way_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_cache_access_ctrl.sv
// Randomized scoreboard bench for l1_cache_access_ctrl with a behavioural
// cache model (per-set tag store plus recency-ordered way list).
module tb_l1_cache_access_ctrl;

    localparam int WAY   = 4;
    localparam int WAY_W = 5;
    localparam int NS    = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req_valid;
    logic         cpu_req_ready;
    logic [31:0]  cpu_req_addr;
    logic         cpu_resp_valid;
    logic         cpu_resp_hit;
    logic [4:0]   cpu_resp_way;
    logic [18:0]  dp_tag;
    logic [8:0]   dp_index;
    logic [3:0]   dp_block_offset;
    logic         dp_find_start;
    logic         dp_done;
    logic         dp_found;
    logic [4:0]   dp_hit_way;
    logic         dp_update_start;
    logic [127:0] dp_block;
    logic         dp_replace;
    logic         dp_block_replace;
    logic [4:0]   dp_replace_way;
    logic         dp_updated;
    logic [4:0]   dp_fill_way;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;

    always #5 clk = ~clk;

    l1_cache_access_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_req_valid    (cpu_req_valid),
        .cpu_req_ready    (cpu_req_ready),
        .cpu_req_addr     (cpu_req_addr),
        .cpu_resp_valid   (cpu_resp_valid),
        .cpu_resp_hit     (cpu_resp_hit),
        .cpu_resp_way     (cpu_resp_way),
        .dp_tag           (dp_tag),
        .dp_index         (dp_index),
        .dp_block_offset  (dp_block_offset),
        .dp_find_start    (dp_find_start),
        .dp_done          (dp_done),
        .dp_found         (dp_found),
        .dp_hit_way       (dp_hit_way),
        .dp_update_start  (dp_update_start),
        .dp_block         (dp_block),
        .dp_replace       (dp_replace),
        .dp_block_replace (dp_block_replace),
        .dp_replace_way   (dp_replace_way),
        .dp_updated       (dp_updated),
        .dp_fill_way      (dp_fill_way),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_data     (mem_rsp_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit         hit;
        logic [4:0] way;
    } exp_t;
    exp_t exp_q[$];

    // Model: the datapath tag store and, per set, ways listed most-recent first.
    logic [8:0]  sets  [NS];
    logic [18:0] m_tag [NS][WAY];
    bit          m_vld [NS][WAY];
    int          ord   [NS][WAY];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [8:0] idx);
        for (int s = 0; s < NS; s++) begin
            if (sets[s] == idx) return s;
        end
        return 0;
    endfunction

    task automatic model_lru_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < WAY; w++) ord[s][w] = w;
        end
    endtask

    task automatic model_touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < WAY; i++) begin
            if (ord[s][i] == w) p = i;
        end
        for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
        ord[s][0] = w;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_hit", cpu_resp_hit, e.hit);
                chk("resp_way", cpu_resp_way, e.way);
            end
        end
    end

    task automatic do_access(input logic [31:0] a, input logic [127:0] fdata,
                             input int mem_delay, input bit stray, input bit abort);
        logic [18:0] tag;
        logic [8:0]  idx;
        logic [31:0] line;
        int          s, way, free, guard, lat;
        bit          hit, repl;
        exp_t        e;

        tag  = a[31:13];
        idx  = a[12:4];
        line = {a[31:4], 4'h0};
        s    = slot_of(idx);
        hit  = 0;
        way  = 0;
        repl = 0;
        for (int w = 0; w < WAY; w++) begin
            if (m_vld[s][w] && m_tag[s][w] == tag) begin
                hit = 1;
                way = w;
            end
        end
        if (!hit) begin
            free = -1;
            for (int w = WAY - 1; w >= 0; w--) begin
                if (!m_vld[s][w]) free = w;
            end
            if (free >= 0) way = free;
            else begin
                repl = 1;
                way  = ord[s][WAY-1];
            end
        end

        guard = 0;
        while (cpu_req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready", cpu_req_ready, 1'b1);

        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        e.hit = hit;
        e.way = 5'(way);
        exp_q.push_back(e);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = $urandom;
        chk("find_start", dp_find_start, 1'b1);
        chk("dp_index", dp_index, idx);
        chk("dp_tag", dp_tag, tag);
        chk("dp_offset", dp_block_offset, a[3:0]);

        lat = $urandom_range(1, 3);
        for (int k = 1; k < lat; k++) begin
            dp_updated = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("find_pulse_once", dp_find_start, 1'b0);
        end
        dp_updated = 1'b0;
        dp_done    = 1'b1;
        dp_found   = hit;
        dp_hit_way = hit ? 5'(way) : 5'($urandom_range(0, WAY - 1));
        @(negedge clk);
        dp_done  = 1'b0;
        dp_found = 1'b0;

        if (hit) begin
            chk("hit_latency", cpu_resp_valid, 1'b1);
            chk("hit_no_memreq", mem_req_valid, 1'b0);
            model_touch(s, way);
            @(negedge clk);
            return;
        end

        for (int i = 0; i <= mem_delay; i++) begin
            chk("mem_req_valid", mem_req_valid, 1'b1);
            chk("mem_req_addr", mem_req_addr, line);
            mem_req_ready = (i == mem_delay);
            mem_rsp_valid = stray && (i == 0);
            mem_rsp_data  = rnd128();
            cpu_req_addr  = $urandom;
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk("mem_req_drop", mem_req_valid, 1'b0);

        if (abort) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            void'(exp_q.pop_back());
            model_lru_reset();
            chk("abort_ready", cpu_req_ready, 1'b1);
            chk("abort_no_resp", cpu_resp_valid, 1'b0);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = fdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            chk("late_rsp_no_fill", dp_update_start, 1'b0);
            chk("late_rsp_ready", cpu_req_ready, 1'b1);
            chk("late_rsp_no_resp", cpu_resp_valid, 1'b0);
            return;
        end

        repeat ($urandom_range(0, 2)) @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = fdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = rnd128();
        chk("update_start", dp_update_start, 1'b1);
        chk("dp_block", dp_block, fdata);
        chk("fill_index", dp_index, idx);
        chk("fill_tag", dp_tag, tag);

        dp_replace = repl;
        @(negedge clk);
        chk("update_pulse_once", dp_update_start, 1'b0);
        chk("block_replace", dp_block_replace, repl);
        if (repl) chk("replace_way", dp_replace_way, 5'(way));
        repeat ($urandom_range(0, 2)) begin
            dp_done = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        dp_done     = 1'b0;
        dp_updated  = 1'b1;
        dp_fill_way = repl ? 5'((way + 1) % WAY) : 5'(way);
        @(negedge clk);
        dp_updated = 1'b0;
        dp_replace = 1'b0;
        chk("miss_resp_valid", cpu_resp_valid, 1'b1);
        chk("replace_dropped", dp_block_replace, 1'b0);

        m_vld[s][way] = 1'b1;
        m_tag[s][way] = tag;
        model_touch(s, way);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        sets[0] = 9'h123;
        sets[1] = 9'h000;
        sets[2] = 9'h1FF;
        sets[3] = 9'h055;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < WAY; w++) begin
                m_vld[s][w] = 1'b0;
                m_tag[s][w] = '0;
            end
        end
        model_lru_reset();

        rst_n         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        dp_done       = 1'b0;
        dp_found      = 1'b0;
        dp_hit_way    = '0;
        dp_replace    = 1'b0;
        dp_updated    = 1'b0;
        dp_fill_way   = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", cpu_req_ready, 1'b1);
        chk("rst_resp_valid", cpu_resp_valid, 1'b0);
        chk("rst_resp_hit", cpu_resp_hit, 1'b0);
        chk("rst_resp_way", cpu_resp_way, 5'd0);
        chk("rst_find", dp_find_start, 1'b0);
        chk("rst_update", dp_update_start, 1'b0);
        chk("rst_block_replace", dp_block_replace, 1'b0);
        chk("rst_replace_way", dp_replace_way, 5'd0);
        chk("rst_mem_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_req_addr, 32'h0);
        chk("rst_block", dp_block, 128'h0);
        chk("rst_tag_index", {dp_tag, dp_index, dp_block_offset}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss into set 0x123, then hit on the same line.
        do_access(32'h0000_1230, {16{8'hA5}}, 0, 1'b0, 1'b0);
        do_access(32'h0000_1230, rnd128(), 0, 1'b0, 1'b0);
        // Fill the remaining ways, then force replacement of the LRU way.
        for (int t = 1; t <= 3; t++) begin
            do_access({19'(t), 9'h123, 4'(t)}, rnd128(), 1, 1'b0, 1'b0);
        end
        do_access({19'd5, 9'h123, 4'h8}, rnd128(), 0, 1'b0, 1'b0);
        // A hit on way 2 must steer the next victim away from it.
        do_access({19'd2, 9'h123, 4'h0}, rnd128(), 0, 1'b0, 1'b0);
        do_access({19'd6, 9'h123, 4'h0}, rnd128(), 0, 1'b0, 1'b0);
        // Long memory stall with a stray response before the request is taken.
        do_access({19'd1, 9'h055, 4'h3}, rnd128(), 10, 1'b1, 1'b0);
        // Reset while waiting for memory, then confirm the LRU is back to initial.
        do_access({19'd7, 9'h123, 4'h0}, rnd128(), 0, 1'b0, 1'b1);
        do_access({19'd8, 9'h123, 4'h0}, rnd128(), 0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = {19'($urandom_range(0, 7)), sets[$urandom_range(0, NS - 1)],
                 4'($urandom_range(0, 15))};
            do_access(a, rnd128(), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 14) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("pending_resp", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
